// File: rtl/add16_seq_if.sv
// Request/result bus of add16_seq; the Sub request bit only exists when
// ADD16_SEQ_SUB_EN is defined.
interface add16_seq_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         in_vld;
  logic         in_rdy;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         out_vld;
  logic         out_rdy;
  logic [W-1:0] S;
  logic         Cout;
  logic         Ovf;
`ifdef ADD16_SEQ_SUB_EN
  logic         Sub;

  modport master (
    output in_vld, A, B, Cin, Sub, out_rdy,
    input  in_rdy, out_vld, S, Cout, Ovf
  );
  modport slave (
    input  in_vld, A, B, Cin, Sub, out_rdy,
    output in_rdy, out_vld, S, Cout, Ovf
  );
`else
  modport master (
    output in_vld, A, B, Cin, out_rdy,
    input  in_rdy, out_vld, S, Cout, Ovf
  );
  modport slave (
    input  in_vld, A, B, Cin, out_rdy,
    output in_rdy, out_vld, S, Cout, Ovf
  );
`endif
endinterface

// File: rtl/add16_seq.sv
// Nibble-serial adder: one 4-bit ripple-carry slice reused NIBBLES times per request.
// Optional subtract mode is built in when ADD16_SEQ_SUB_EN is defined.
module rca4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic c;

  always_comb begin
    c = ci;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end
endmodule

module add16_seq #(
  parameter int NIBBLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  add16_seq_if.slave  bus
);
  localparam int W     = 4 * NIBBLES;
  localparam int CNT_W = $clog2(NIBBLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic               accept;
  logic               step;
  logic               last;

  logic [W-1:0]       a_op;
  logic [W-1:0]       b_op;
  logic [W-1:0]       b_in;
  logic               c_in;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W+1:0]   base;
  logic [W-1:0]       sum;
  logic               cout;
  logic               ovf;

  logic [3:0]         nib_a;
  logic [3:0]         nib_b;
  logic [3:0]         nib_s;
  logic               nib_co;

  // Subtraction stores ~B and seeds the carry with 1; the overflow rule
  // below then covers both modes because b_op already holds the inverted MSB.
`ifdef ADD16_SEQ_SUB_EN
  assign b_in = bus.Sub ? ~bus.B : bus.B;
  assign c_in = bus.Sub | bus.Cin;
`else
  assign b_in = bus.B;
  assign c_in = bus.Cin;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_vld) begin
          accept     = 1'b1;
          state_next = ADD;
        end
      end
      ADD: begin
        step = 1'b1;
        if (cnt == LAST) begin
          last       = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_rdy) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign base  = {cnt, 2'b00};
  assign nib_a = a_op[base +: 4];
  assign nib_b = b_op[base +: 4];

  rca4 u_rca4 (
    .a  (nib_a),
    .b  (nib_b),
    .ci (carry),
    .s  (nib_s),
    .co (nib_co)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      a_op <= bus.A;
      b_op <= b_in;
    end
  end

  // Serial stage: one nibble of sum per ADD cycle, flags latched on the last one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      carry <= c_in;
    end else if (step) begin
      sum[base +: 4] <= nib_s;
      carry          <= nib_co;
      cnt            <= cnt + 1'b1;
      if (last) begin
        cout <= nib_co;
        ovf  <= (a_op[W-1] == b_op[W-1]) && (nib_s[3] != a_op[W-1]);
      end
    end
  end

  assign bus.in_rdy  = (state == IDLE);
  assign bus.out_vld = (state == HOLD);
  assign bus.S       = sum;
  assign bus.Cout    = cout;
  assign bus.Ovf     = ovf;
endmodule
